// File: rtl/systolic_pkg.sv
// Shared constants for the 4x4 systolic array and its result drain.
// Holds the array defaults, drain FSM states and checksum width.
package systolic_pkg;

  localparam int SYS_N   = 4;
  localparam int SYS_DW  = 16;
  localparam int SYS_IW  = 4;
  localparam int SYS_CSW = SYS_DW + SYS_IW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/result_buffer.sv
// N*N x DW snapshot register file for the result drain.
// Loads every word in parallel, reads one word by index.
module result_buffer
  import systolic_pkg::*;
#(
  parameter int N  = SYS_N,
  parameter int DW = SYS_DW,
  parameter int IW = SYS_IW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [N*N*DW-1:0]   i_data,
  input  logic [IW-1:0]       i_idx,
  output logic [DW-1:0]       o_data
);

  logic [DW-1:0] r_mem [N*N];

  // snapshot all words at once when the drain captures
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N*N; i++)
        r_mem[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < N*N; i++)
        r_mem[i] <= i_data[i*DW +: DW];
    end
  end

  assign o_data = r_mem[i_idx];

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots systolic array results on done and streams them out.
// Optional DRAIN_CHECKSUM_EN adds out_csum, the sum of the snapshot.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int N  = SYS_N,
  parameter int DW = SYS_DW,
  parameter int IW = SYS_IW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [N*N*DW-1:0] res_flat,
  output logic [DW-1:0]     out_data,
  output logic [IW-1:0]     out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr
`ifdef DRAIN_CHECKSUM_EN
  ,
  output logic [DW+IW-1:0]  out_csum
`endif
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_done_d;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic          r_ovr;
  logic          w_ovr_nxt;
  logic          w_cap;
  logic          w_hs;
  logic          w_last;
  logic          w_load;
  logic          w_drain;
  logic [DW-1:0] w_rd;

  assign w_drain = (r_state == ST_DRAIN);
  assign w_cap   = done & ~r_done_d;
  assign w_hs    = w_drain & out_ready;
  assign w_last  = (r_idx == IW'(N*N-1));

  // next state, index and overrun flag
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ovr_nxt   = r_ovr;
    w_load      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cap) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_hs && w_last) begin
          w_idx_nxt = '0;
          if (w_cap)
            w_load = 1'b1;
          else
            w_state_nxt = ST_IDLE;
        end else begin
          if (w_hs)
            w_idx_nxt = r_idx + 1'b1;
          if (w_cap)
            w_ovr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (overrun_clr)
      w_ovr_nxt = 1'b0;
  end

  // state, index, edge-detect and sticky overrun registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_done_d <= 1'b0;
      r_idx    <= '0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_done_d <= done;
      r_idx    <= w_idx_nxt;
      r_ovr    <= w_ovr_nxt;
    end
  end

  result_buffer #(
    .N  (N),
    .DW (DW),
    .IW (IW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_data (res_flat),
    .i_idx  (r_idx),
    .o_data (w_rd)
  );

  assign out_data  = w_rd;
  assign out_idx   = r_idx;
  assign out_valid = w_drain;
  assign busy      = w_drain;
  assign out_last  = w_drain & w_last;
  assign overrun   = r_ovr;

`ifdef DRAIN_CHECKSUM_EN
  logic [DW+IW-1:0] w_csum;
  logic [DW+IW-1:0] r_csum;

  // sum of the words being captured
  always_comb begin
    w_csum = '0;
    for (int i = 0; i < N*N; i++)
      w_csum = w_csum + {{IW{1'b0}}, res_flat[i*DW +: DW]};
  end

  // hold the checksum of the current snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_csum <= '0;
    else if (w_load)
      r_csum <= w_csum;
  end

  assign out_csum = r_csum;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: queue model plus literal pins.
// Build with DRAIN_CHECKSUM_EN to also check out_csum.
module tb_systolic_result_drain;
  import systolic_pkg::*;

  localparam int NN = SYS_N * SYS_N;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  done = 1'b0;
  logic [NN*SYS_DW-1:0]  res_flat = '0;
  logic [SYS_DW-1:0]     out_data;
  logic [SYS_IW-1:0]     out_idx;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic                  out_last;
  logic                  busy;
  logic                  overrun;
  logic                  overrun_clr = 1'b0;
`ifdef DRAIN_CHECKSUM_EN
  logic [SYS_CSW-1:0]    out_csum;
`endif

  int n_chk = 0;
  int n_fail = 0;

  systolic_result_drain dut (
    .clk         (clk),
    .rst         (rst),
    .done        (done),
    .res_flat    (res_flat),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`ifdef DRAIN_CHECKSUM_EN
    ,
    .out_csum    (out_csum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // model: the words still owed to the sink, oldest first
  logic [15:0] mq[$];
  bit          m_ovr;
  bit          m_done_d;
  logic [19:0] m_csum;
  bit          m_cap;
  bit          m_bsy;
  bit          m_hs;
  bit          m_lst;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ovr    = 0;
      m_done_d = 0;
      m_csum   = '0;
    end else begin
      m_cap = done && !m_done_d;
      m_bsy = mq.size() > 0;
      m_hs  = m_bsy && out_ready;
      m_lst = mq.size() == 1;
      if (m_hs)
        void'(mq.pop_front());
      if (m_cap) begin
        if (!m_bsy || (m_hs && m_lst)) begin
          m_csum = '0;
          for (int i = 0; i < NN; i++) begin
            mq.push_back(res_flat[i*16 +: 16]);
            m_csum = m_csum + 20'(res_flat[i*16 +: 16]);
          end
        end else begin
          m_ovr = 1;
        end
      end
      if (overrun_clr)
        m_ovr = 0;
      m_done_d = done;
    end
  end

  // compare DUT against the model every cycle out of reset
  always @(negedge clk) begin
    if (rst) begin
      chk("valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("busy", 32'(busy), 32'(mq.size() > 0));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (mq.size() > 0) begin
        chk("data", 32'(out_data), 32'(mq[0]));
        chk("idx", 32'(out_idx), 32'(NN - mq.size()));
        chk("last", 32'(out_last), 32'(mq.size() == 1));
`ifdef DRAIN_CHECKSUM_EN
        chk("csum", 32'(out_csum), 32'(m_csum));
`endif
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_res();
    for (int i = 0; i < NN; i++)
      res_flat[i*16 +: 16] = 16'($urandom);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic wait_left(input int k);
    for (int c = 0; c < 200 && mq.size() != k; c++)
      step();
    if (mq.size() != k)
      chk("wait_timeout", 32'(mq.size()), 32'(k));
  endtask

  initial begin
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    rst = 1'b1;
    step();

    // basic stream
    for (int i = 0; i < NN; i++)
      res_flat[i*16 +: 16] = 16'h0100 + 16'(i);
    out_ready = 1'b1;
    done = 1'b1;
    @(negedge clk);
    chk("s1_d0", 32'(out_data), 32'h0100);
    chk("s1_i0", 32'(out_idx), 32'd0);
    chk("s1_v0", 32'(out_valid), 32'd1);
`ifdef DRAIN_CHECKSUM_EN
    chk("s1_csum", 32'(out_csum), 32'h01078);
`endif
    #1;
    done = 1'b0;
    for (int b = 1; b < NN; b++) begin
      @(negedge clk);
      chk("s1_seq", 32'(out_data), 32'h0100 + 32'(b));
      chk("s1_last", 32'(out_last), 32'(b == 15));
    end
    @(negedge clk);
    chk("s1_busy_end", 32'(busy), 32'd0);
    #1;

    // backpressure 1,0,0,1
    rand_res();
    pulse_done();
    for (int c = 0; c < 200 && mq.size() > 0; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      step();
    end
    chk("s2_drained", 32'(busy), 32'd0);

    // level done held high
    rand_res();
    out_ready = 1'b1;
    done = 1'b1;
    repeat (40) step();
    done = 1'b0;
    chk("s3_ovr", 32'(overrun), 32'd0);
    chk("s3_busy", 32'(busy), 32'd0);
    step();

    // overrun at idx 3
    rand_res();
    pulse_done();
    wait_left(13);
    out_ready = 1'b0;
    rand_res();
    done = 1'b1;
    step();
    chk("s4_ovr", 32'(overrun), 32'd1);
    chk("s4_idx", 32'(out_idx), 32'd3);
    done = 1'b0;
    overrun_clr = 1'b1;
    step();
    chk("s4_clr", 32'(overrun), 32'd0);
    overrun_clr = 1'b0;
    out_ready = 1'b1;
    wait_left(0);
    step();

    // back-to-back on the last beat
    rand_res();
    pulse_done();
    wait_left(1);
    for (int i = 0; i < NN; i++)
      res_flat[i*16 +: 16] = 16'(i * 3);
    done = 1'b1;
    step();
    chk("s5_idx0", 32'(out_idx), 32'd0);
    chk("s5_d0", 32'(out_data), 32'd0);
    chk("s5_v", 32'(out_valid), 32'd1);
    chk("s5_ovr", 32'(overrun), 32'd0);
    done = 1'b0;
    step();
    chk("s5_d1", 32'(out_data), 32'd3);
    wait_left(0);
    step();

    // async reset mid-drain
    rand_res();
    pulse_done();
    wait_left(9);
    chk("s6_idx7", 32'(out_idx), 32'd7);
    #2;
    rst = 1'b0;
    #1;
    chk("s6_valid", 32'(out_valid), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    repeat (5) step();
    chk("s6_idle", 32'(out_valid), 32'd0);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!done && $urandom_range(0, 19) == 0) begin
        rand_res();
        done = 1'b1;
      end else if (done && $urandom_range(0, 2) == 0) begin
        done = 1'b0;
      end
      overrun_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    done = 1'b0;
    overrun_clr = 1'b0;
    out_ready = 1'b1;
    wait_left(0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
